grom8_cpu: RTL and testbench

Minimal 8-bit multi-cycle CPU with a 12-bit address space, four 8-bit general registers, a 12-bit address register and zero/carry flags. It is the processor core of the grom system. It sits on a single shared bus:
- memory accesses go to an external synchronous RAM (ram_memory);
- I/O accesses are distinguished by `ioreq`, and the system gates RAM writes as `we & ~ioreq`.

---
 rtl/grom8_cpu.sv | 225 ++++++++++++++++++++++
 tb/tb_grom8_cpu.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/grom8_cpu.sv
// grom8_cpu: minimal 8-bit multi-cycle CPU with a 12-bit address space.
// Architectural state is R0-R3 (8 bit), PC and AR (12 bit), IR, IMM and the Z/C flags.
// Every bus output is a register, and each register is loaded with the value that the
// following state must present. Because of this, no combinational path runs from data_in
// to any output.
//
// Ports:
//   clk       system clock; all state updates on the rising edge
//   reset     synchronous, active-high reset
//   addr      memory / I/O address
//   data_in   read data from RAM or I/O, valid one cycle after addr
//   data_out  write data for STORE / OUT; holds the last written value
//   we        write strobe, one cycle per STORE / OUT
//   ioreq     marks the current bus cycle as I/O (IN / OUT)
//   hlt       high once HLT has executed; cleared only by reset
module grom8_cpu (
  input  logic        clk,
  input  logic        reset,
  output logic [11:0] addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        we,
  output logic        ioreq,
  output logic        hlt
);

  localparam logic [2:0] StFetch  = 3'd0;
  localparam logic [2:0] StDecode = 3'd1;
  localparam logic [2:0] StFetch2 = 3'd2;
  localparam logic [2:0] StImm    = 3'd3;
  localparam logic [2:0] StExec   = 3'd4;
  localparam logic [2:0] StMemRd  = 3'd5;
  localparam logic [2:0] StHalt   = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [11:0] ar_q, ar_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  imm_q, imm_d;
  logic [7:0]  dout_q, dout_d;
  logic        z_q, z_d;
  logic        c_q, c_d;
  logic        we_q, we_d;
  logic        io_q, io_d;
  logic        hlt_q, hlt_d;
  logic [7:0]  regs_q [4];
  logic [7:0]  regs_d [4];

  // Opcodes that carry a second byte (immediate, port or low address).
  function automatic logic is_two_byte(input logic [7:0] op);
    return (op[7:6] == 2'b11) || (op[7:2] == 6'b101010) ||
           (op[7:2] == 6'b101011) || (op[7:2] == 6'b101100);
  endfunction

  // ALU: bit 8 of alu_res is the carry/borrow out. For SHR it is the shifted-out bit.
  logic [7:0] opa, opb;
  logic [8:0] alu_res;
  logic [1:0] alu_dst;
  logic       is_alu;

  always_comb begin
    opa     = regs_q[ir_q[3:2]];
    opb     = regs_q[ir_q[1:0]];
    alu_dst = (ir_q[7:4] == 4'h9) ? ir_q[1:0] : ir_q[3:2];
    is_alu  = (ir_q[7] == 1'b0) || (ir_q[7:4] == 4'h8) || (ir_q[7:4] == 4'h9);
    alu_res = '0;
    case (ir_q[7:4])
      4'h0:       alu_res = {1'b0, opb};
      4'h1:       alu_res = {1'b0, opa} + {1'b0, opb};
      4'h2, 4'h8: alu_res = {1'b0, opa} - {1'b0, opb};
      4'h3:       alu_res = {1'b0, opa} + {1'b0, opb} + {8'h00, c_q};
      4'h4:       alu_res = {1'b0, opa} - {1'b0, opb} - {8'h00, c_q};
      4'h5:       alu_res = {1'b0, opa & opb};
      4'h6:       alu_res = {1'b0, opa | opb};
      4'h7:       alu_res = {1'b0, opa ^ opb};
      4'h9: begin
        case (ir_q[3:2])
          2'b00:   alu_res = {1'b0, opb} + 9'd1;
          2'b01:   alu_res = {1'b0, opb} - 9'd1;
          2'b10:   alu_res = {1'b0, ~opb};
          default: alu_res = {opb[0], 1'b0, opb[7:1]};
        endcase
      end
      default:    alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ar_d    = ar_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    dout_d  = dout_q;
    z_d     = z_q;
    c_d     = c_q;
    we_d    = 1'b0;
    io_d    = 1'b0;
    hlt_d   = hlt_q;
    regs_d  = regs_q;

    case (state_q)
      StFetch: state_d = StDecode;

      StDecode: begin
        ir_d = data_in;
        pc_d = pc_q + 12'd1;
        if (is_two_byte(data_in)) begin
          state_d = StFetch2;
          addr_d  = pc_q + 12'd1;
        end else begin
          state_d = StExec;
          // LOAD / STORE put AR on the bus during EXEC
          if (data_in[7:2] == 6'b101000) begin
            addr_d = ar_q;
          end else if (data_in[7:2] == 6'b101001) begin
            addr_d = ar_q;
            dout_d = regs_q[data_in[1:0]];
            we_d   = 1'b1;
          end
        end
      end

      StFetch2: state_d = StImm;

      StImm: begin
        imm_d   = data_in;
        pc_d    = pc_q + 12'd1;
        state_d = StExec;
        if (ir_q[7:2] == 6'b101010) begin
          addr_d = {4'h0, data_in};
          io_d   = 1'b1;
        end else if (ir_q[7:2] == 6'b101011) begin
          addr_d = {4'h0, data_in};
          io_d   = 1'b1;
          we_d   = 1'b1;
          dout_d = regs_q[ir_q[1:0]];
        end
      end

      StExec: begin
        state_d = StFetch;
        addr_d  = pc_q;
        if (is_alu) begin
          if (ir_q[7:4] != 4'h8) regs_d[alu_dst] = alu_res[7:0];
          if (ir_q[7:4] != 4'h0) begin
            z_d = (alu_res[7:0] == 8'h00);
            c_d = alu_res[8];
          end
        end else if (ir_q[7:6] == 2'b11) begin
          case (ir_q[5:4])
            2'b10: ar_d = {ir_q[3:0], imm_q};
            default: begin
              if ((ir_q[5:4] == 2'b00) || (ir_q[5:4] == 2'b01 && z_q) ||
                  (ir_q[5:4] == 2'b11 && c_q)) begin
                pc_d   = {ir_q[3:0], imm_q};
                addr_d = {ir_q[3:0], imm_q};
              end
            end
          endcase
        end else begin
          case (ir_q[5:2])
            4'b1000, 4'b1010: state_d = StMemRd;
            4'b1100:          regs_d[ir_q[1:0]] = imm_q;
            4'b1111: begin
              state_d = StHalt;
              hlt_d   = 1'b1;
            end
            default: ;
          endcase
        end
      end

      StMemRd: begin
        regs_d[ir_q[1:0]] = data_in;
        state_d           = StFetch;
      end

      StHalt: state_d = StHalt;

      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= '0;
      ar_q    <= '0;
      addr_q  <= '0;
      ir_q    <= '0;
      imm_q   <= '0;
      dout_q  <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      we_q    <= 1'b0;
      io_q    <= 1'b0;
      hlt_q   <= 1'b0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ar_q    <= ar_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
      dout_q  <= dout_d;
      z_q     <= z_d;
      c_q     <= c_d;
      we_q    <= we_d;
      io_q    <= io_d;
      hlt_q   <= hlt_d;
      for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign addr     = addr_q;
  assign data_out = dout_q;
  assign we       = we_q;
  assign ioreq    = io_q;
  assign hlt      = hlt_q;

endmodule

// File: tb/tb_grom8_cpu.sv
// Testbench for grom8_cpu: runs a small program from a RAM model.
// Every expected bus write is queued when the program is loaded and popped when
// the CPU drives we.
module tb_grom8_cpu;

  logic        clk;
  logic        reset;
  logic [11:0] addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        we;
  logic        ioreq;
  logic        hlt;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem [4096];
  logic [7:0]  rdata;
  logic        we_prev;
  logic [20:0] sb [$];  // {ioreq, addr, data}

  grom8_cpu dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .we       (we),
    .ioreq    (ioreq),
    .hlt      (hlt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The RAM has a registered read. An I/O read returns {A, port[3:0]}.
  always @(posedge clk) begin
    if (we && !ioreq) mem[addr] <= data_out;
    rdata <= ioreq ? {4'hA, addr[3:0]} : mem[addr];
  end
  assign data_in = rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor: compares each write against the scoreboard and checks that we lasts one cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (we_prev) check("we_one_cycle", {31'd0, we}, 32'd0);
      if (we) begin
        if (sb.size() == 0) begin
          check("unexpected_write", {11'd0, ioreq, addr, data_out}, 32'd0);
        end else begin
          check("bus_write", {11'd0, ioreq, addr, data_out}, {11'd0, sb.pop_front()});
        end
      end
    end
    we_prev <= we && !reset;
  end

  logic [7:0] prog [$] = '{
    8'hB0, 8'hF0, 8'hB1, 8'h20, 8'h11, 8'hAC, 8'h20, 8'hB2, 8'h00, 8'h3A,  // 000
    8'hAE, 8'h21, 8'h20, 8'hD0, 8'h12, 8'hAC, 8'h2F, 8'h00, 8'hE1, 8'h00,  // 00A
    8'hB2, 8'h5A, 8'hA6, 8'hA3, 8'hAF, 8'h10, 8'h8E, 8'hF0, 8'h20, 8'hC0,  // 014
    8'h22, 8'h00, 8'hAC, 8'h2E, 8'hB0, 8'h00, 8'h94, 8'hAC, 8'h30, 8'hB1,  // 01E
    8'h00, 8'h35, 8'hAD, 8'h31, 8'h90, 8'hB2, 8'h05, 8'hB3, 8'h03, 8'h4E,  // 028
    8'hAF, 8'h32, 8'hB0, 8'h3C, 8'hB1, 8'h0F, 8'h51, 8'hAC, 8'h33, 8'h61,  // 032
    8'h71, 8'h98, 8'h9C, 8'hAC, 8'h34, 8'hB2, 8'h00, 8'h3A, 8'h06, 8'hAD,  // 03C
    8'h35, 8'hE3, 8'h00, 8'hA5, 8'hA9, 8'h07, 8'hAD, 8'h36, 8'hBC          // 046
  };

  int          cyc;
  int          halt_bad;
  logic [11:0] halt_addr;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    for (int i = 0; i < prog.size(); i++) mem[i] = prog[i];
    // Expected bus writes, in program order
    sb.push_back({1'b1, 12'h020, 8'h10});  // ADD F0+20
    sb.push_back({1'b1, 12'h021, 8'h01});  // ADC reveals C=1
    sb.push_back({1'b0, 12'h100, 8'h5A});  // STORE
    sb.push_back({1'b1, 12'h010, 8'h5A});  // LOAD result via OUT
    sb.push_back({1'b1, 12'h030, 8'hFF});  // DEC 00
    sb.push_back({1'b1, 12'h031, 8'h01});  // borrow from DEC
    sb.push_back({1'b1, 12'h032, 8'hFD});  // SBC 3-5-1
    sb.push_back({1'b1, 12'h033, 8'h0C});  // AND
    sb.push_back({1'b1, 12'h034, 8'h7F});  // OR/XOR/NOT/SHR chain
    sb.push_back({1'b1, 12'h035, 8'h01});  // C from SHR
    sb.push_back({1'b0, 12'h300, 8'h01});  // STORE to AR=300
    sb.push_back({1'b1, 12'h036, 8'hA7});  // IN (07)

    we_prev = 1'b0;
    reset   = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (7) @(negedge clk);  // part-way into the second instruction
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    cyc = 1;
    check("rst_addr", {20'd0, addr}, 32'h000);
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_ioreq", {31'd0, ioreq}, 32'd0);
    check("rst_hlt", {31'd0, hlt}, 32'd0);
    while (!hlt && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 4) check("addr_cycle4", {20'd0, addr}, 32'h001);
    end
    check("hlt_reached", {31'd0, hlt}, 32'd1);
    check("hlt_cycle", cyc, 195);

    halt_addr = addr;
    halt_bad  = 0;
    repeat (50) begin
      @(negedge clk);
      if (addr !== halt_addr || we !== 1'b0 || hlt !== 1'b1) halt_bad++;
    end
    check("halt_stable", halt_bad, 0);

    check("sb_empty", sb.size(), 0);
    check("mem_100", {24'd0, mem[12'h100]}, 32'h5A);
    check("mem_300", {24'd0, mem[12'h300]}, 32'h01);
    check("mem_010_untouched", {24'd0, mem[12'h010]}, 32'h2F);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rerst_hlt", {31'd0, hlt}, 32'd0);
    check("rerst_addr", {20'd0, addr}, 32'h000);
    @(negedge clk);
    check("rerst_decode_addr", {20'd0, addr}, 32'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
